// File: rtl/rf_sequencer.sv
// rtl/rf_sequencer.sv - multicycle fetch/decode/execute sequencer owning a 4x8 register file
module rf_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [1:0]      rf_addra,
  output logic [1:0]      rf_addrb,
  output logic [1:0]      rf_addrw,
  output logic            rf_we,
  output logic [7:0]      rf_wd,
  input  logic [7:0]      rf_a,
  input  logic [7:0]      rf_b,
  output logic            busy,
  output logic            halted,
  output logic            flag_z,
  output logic            flag_c
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_EXEC, S_HALTED
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic            z_q;
  logic            c_q;

  logic [3:0] op;
  logic [8:0] sum;
  logic [7:0] alu_res;
  logic       alu_c;

  assign op = ir_q[7:4];

  always_comb begin
    sum     = {1'b0, rf_a} + {1'b0, rf_b};
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (op)
      4'h1: alu_res = rf_b;
      4'h2: begin alu_res = sum[7:0]; alu_c = sum[8]; end
      4'h3: begin alu_res = rf_a - rf_b; alu_c = (rf_a < rf_b); end
      4'h4: alu_res = rf_a & rf_b;
      4'h5: alu_res = rf_a | rf_b;
      4'h6: alu_res = rf_a ^ rf_b;
      4'h7: alu_res = ~rf_a;
      default: alu_res = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            pc_q    <= pc_q + PC_W'(1);
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == 4'hF)                        state_q <= S_HALTED;
          else if (op == 4'h8)                   state_q <= S_IMM;
          else if (op != 4'h0 && op < 4'h8)      state_q <= S_EXEC;
          else                                   state_q <= S_FETCH;
        end
        S_IMM: begin
          if (imem_ack) begin
            pc_q    <= pc_q + PC_W'(1);
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          // MOV is a pure copy and must not disturb the flags
          if (op != 4'h1) begin
            z_q <= (alu_res == 8'h00);
            c_q <= alu_c;
          end
          state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write strobe and data are decoded from state so an async reset kills them at once
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_IMM);
  assign imem_addr = pc_q;
  assign rf_addra  = ir_q[3:2];
  assign rf_addrb  = ir_q[1:0];
  assign rf_addrw  = ir_q[3:2];
  assign rf_we     = (state_q == S_EXEC) || ((state_q == S_IMM) && imem_ack);
  assign rf_wd     = (state_q == S_EXEC) ? alu_res :
                     ((state_q == S_IMM) && imem_ack) ? imem_rdata : 8'h00;
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted    = (state_q == S_HALTED);
  assign flag_z    = z_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// tb/tb_rf_sequencer.sv - directed bench for rf_sequencer with register file and memory models
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [1:0] rf_addra, rf_addrb, rf_addrw;
  logic       rf_we;
  logic [7:0] rf_wd, rf_a, rf_b;
  logic       busy, halted, flag_z, flag_c;

  logic       start2;
  logic       req2;
  logic [1:0] addr2;
  logic [1:0] ra2, rb2, rw2;
  logic       we2;
  logic [7:0] wd2;
  logic       busy2, halted2, z2, c2;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  rf_sequencer #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_addra(rf_addra), .rf_addrb(rf_addrb), .rf_addrw(rf_addrw),
    .rf_we(rf_we), .rf_wd(rf_wd), .rf_a(rf_a), .rf_b(rf_b),
    .busy(busy), .halted(halted), .flag_z(flag_z), .flag_c(flag_c)
  );

  rf_sequencer #(.PC_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(req2), .imem_rdata(8'h00),
    .rf_addra(ra2), .rf_addrb(rb2), .rf_addrw(rw2),
    .rf_we(we2), .rf_wd(wd2), .rf_a(8'h00), .rf_b(8'h00),
    .busy(busy2), .halted(halted2), .flag_z(z2), .flag_c(c2)
  );

  logic [7:0] rf [4];
  assign rf_a = rf[rf_addra];
  assign rf_b = rf[rf_addrb];
  always @(posedge clk) if (rf_we) rf[rf_addrw] <= rf_wd;

  logic [7:0] imem [256];
  int   delay_max = 0;
  int   wait_cnt  = 0;
  int   cur_delay = 0;
  logic hold_ack  = 1'b0;
  logic [7:0] hold_addr = 8'h00;

  assign imem_ack   = imem_req && (wait_cnt >= cur_delay) && !(hold_ack && imem_addr == hold_addr);
  assign imem_rdata = imem[imem_addr];

  always @(posedge clk) begin
    if (!imem_req || imem_ack) begin
      wait_cnt  <= 0;
      cur_delay <= $urandom_range(delay_max, 0);
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  int we_cnt = 0;
  int stab_err = 0;
  logic prev_wait = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  always @(posedge clk) begin
    if (rf_we) we_cnt <= we_cnt + 1;
    if (prev_wait && rst_n && (!imem_req || imem_addr != prev_addr)) stab_err <= stab_err + 1;
    prev_wait <= imem_req && !imem_ack;
    prev_addr <= imem_addr;
  end

  task automatic load(input logic [127:0] b, input int n);
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    for (int i = 0; i < n; i++) imem[i] = b[(n-1-i)*8 +: 8];
  endtask

  task automatic run_prog(output int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++;
    if ({busy, halted, imem_req, rf_we, flag_z, flag_c} !== 6'b0) begin
      err++; $display("FAIL reset_ctl got %b want 000000", {busy, halted, imem_req, rf_we, flag_z, flag_c});
    end
    vec++;
    if ({imem_addr, rf_wd, rf_addra, rf_addrb, rf_addrw} !== 22'h0) begin
      err++; $display("FAIL reset_data got %h want 0", {imem_addr, rf_wd, rf_addra, rf_addrb, rf_addrw});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_prog1;
    int n, w0;
    load(128'h8005840321F0, 6);
    w0 = we_cnt;
    run_prog(n);
    vec++; if (n !== 11) begin err++; $display("FAIL p1_cycles got %0d want 11", n); end
    vec++; if (rf[0] !== 8'h08 || rf[1] !== 8'h03) begin
      err++; $display("FAIL p1_regs got r0=%h r1=%h want 08 03", rf[0], rf[1]); end
    vec++; if ({flag_z, flag_c, halted} !== 3'b001) begin
      err++; $display("FAIL p1_flags got zch=%b want 001", {flag_z, flag_c, halted}); end
    vec++; if (imem_addr !== 8'h06) begin err++; $display("FAIL p1_pc got %h want 06", imem_addr); end
    vec++; if (we_cnt - w0 !== 3) begin err++; $display("FAIL p1_we got %0d want 3", we_cnt - w0); end
  endtask

  task automatic test_flags;
    int n;
    load(128'h80FF840121F0, 6);
    run_prog(n);
    vec++; if (rf[0] !== 8'h00 || {flag_z, flag_c} !== 2'b11) begin
      err++; $display("FAIL add_wrap got r0=%h zc=%b want 00 11", rf[0], {flag_z, flag_c}); end
    load(128'h8000840131F0, 6);
    run_prog(n);
    vec++; if (rf[0] !== 8'hFF || {flag_z, flag_c} !== 2'b01) begin
      err++; $display("FAIL sub_borrow got r0=%h zc=%b want FF 01", rf[0], {flag_z, flag_c}); end
  endtask

  task automatic test_reserved;
    int n, w0;
    logic [7:0] r0;
    load(128'h0095F0, 3);
    w0 = we_cnt; r0 = rf[0];
    run_prog(n);
    vec++; if (n !== 6) begin err++; $display("FAIL nop_cycles got %0d want 6", n); end
    vec++; if (we_cnt - w0 !== 0 || rf[0] !== r0) begin
      err++; $display("FAIL nop_write got we=%0d r0=%h want 0 %h", we_cnt - w0, rf[0], r0); end
    vec++; if ({flag_z, flag_c} !== 2'b01) begin
      err++; $display("FAIL nop_flags got %b want 01", {flag_z, flag_c}); end
  endtask

  task automatic test_logic;
    int n, w0;
    load(128'h88F08C3C124317667CF0, 10);
    w0 = we_cnt;
    run_prog(n);
    vec++; if (n !== 23) begin err++; $display("FAIL logic_cycles got %0d want 23", n); end
    vec++; if ({rf[0], rf[1], rf[2], rf[3]} !== 32'h30CCF0C3) begin
      err++; $display("FAIL logic_regs got %h want 30CCF0C3", {rf[0], rf[1], rf[2], rf[3]}); end
    vec++; if ({flag_z, flag_c} !== 2'b00 || we_cnt - w0 !== 7) begin
      err++; $display("FAIL logic_flags got zc=%b we=%0d want 00 7", {flag_z, flag_c}, we_cnt - w0); end
  endtask

  task automatic test_random_delay;
    int n, w0, s0;
    delay_max = 3;
    s0 = stab_err;
    load(128'h8005840321F0, 6);
    w0 = we_cnt;
    run_prog(n);
    vec++; if (rf[0] !== 8'h08 || rf[1] !== 8'h03 || we_cnt - w0 !== 3 || n < 11 || busy) begin
      err++; $display("FAIL rd_p1 got r0=%h r1=%h we=%0d n=%0d want 08 03 3 >=11", rf[0], rf[1], we_cnt - w0, n); end
    load(128'h88F08C3C124317667CF0, 10);
    w0 = we_cnt;
    run_prog(n);
    vec++; if ({rf[0], rf[1], rf[2], rf[3]} !== 32'h30CCF0C3 || we_cnt - w0 !== 7 || busy) begin
      err++; $display("FAIL rd_logic got %h we=%0d want 30CCF0C3 7", {rf[0], rf[1], rf[2], rf[3]}, we_cnt - w0); end
    vec++; if (stab_err - s0 !== 0) begin err++; $display("FAIL rd_stable got %0d want 0", stab_err - s0); end
    delay_max = 0;
  endtask

  task automatic test_start_busy;
    int n;
    load(128'h8005840321F0, 6);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      n++;
      start = (n == 3 || n == 4);
      @(negedge clk);
    end
    start = 1'b0;
    vec++; if (n !== 11 || rf[0] !== 8'h08) begin
      err++; $display("FAIL start_busy got n=%0d r0=%h want 11 08", n, rf[0]); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vec++; if (!imem_req || imem_addr !== 8'h00) begin
      err++; $display("FAIL restart got req=%b addr=%h want 1 00", imem_req, imem_addr); end
    n = 0;
    while (busy && n < 2000) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset_exec;
    int n, w0;
    bit found;
    load(128'h801120F0, 4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (rf_we && !imem_req) found = 1;
      else @(negedge clk);
    end
    vec++; if (!found) begin err++; $display("FAIL exec_reach got 0 want 1"); end
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    vec++; if ({busy, halted, imem_req, rf_we, flag_z, flag_c, imem_addr, rf_wd} !== 22'h0) begin
      err++; $display("FAIL exec_rst_out got %h want 0", {busy, halted, imem_req, rf_we, flag_z, flag_c, imem_addr, rf_wd}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    vec++; if (rf[0] !== 8'h11 || we_cnt - w0 !== 0 || busy) begin
      err++; $display("FAIL exec_rst_nowrite got r0=%h we=%0d busy=%b want 11 0 0", rf[0], we_cnt - w0, busy); end
    w0 = we_cnt;
    run_prog(n);
    vec++; if (rf[0] !== 8'h22 || we_cnt - w0 !== 2) begin
      err++; $display("FAIL double got r0=%h we=%0d want 22 2", rf[0], we_cnt - w0); end
  endtask

  task automatic test_reset_imm;
    int w0;
    bit found;
    load(128'h8055F0, 3);
    hold_ack = 1'b1; hold_addr = 8'h01;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (imem_req && imem_addr == 8'h01) found = 1;
      else @(negedge clk);
    end
    vec++; if (!found) begin err++; $display("FAIL imm_reach got 0 want 1"); end
    repeat (2) @(negedge clk);
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    vec++; if ({busy, imem_req, rf_we, imem_addr, rf_wd} !== 19'h0) begin
      err++; $display("FAIL imm_rst_out got %h want 0", {busy, imem_req, rf_we, imem_addr, rf_wd}); end
    @(negedge clk); rst_n = 1'b1; hold_ack = 1'b0;
    @(negedge clk);
    vec++; if (rf[0] !== 8'h22 || we_cnt - w0 !== 0 || busy) begin
      err++; $display("FAIL imm_rst_nowrite got r0=%h we=%0d busy=%b want 22 0 0", rf[0], we_cnt - w0, busy); end
  endtask

  task automatic test_pc_wrap;
    int idx;
    logic [1:0] exp_a;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      if (req2) begin
        exp_a = idx[1:0];
        vec++;
        if (addr2 !== exp_a) begin err++; $display("FAIL wrap_addr%0d got %0d want %0d", idx, addr2, exp_a); end
        idx++;
      end
      @(negedge clk);
    end
    vec++; if (idx !== 5) begin err++; $display("FAIL wrap_fetches got %0d want 5", idx); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    test_reset();
    test_prog1();
    test_flags();
    test_reserved();
    test_logic();
    test_random_delay();
    test_start_busy();
    test_reset_exec();
    test_reset_imm();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
